// File: rtl/axi_led_pwm_nch.sv
// axi_led_pwm_nch: NUM_CH-channel LED controller with an AXI4-Lite slave.
// Per channel: off / steady PWM / blink / timed one-shot.
//
// Ports:
//   aclk, aresetn          clock, async active-low reset
//   aw*/w*/b*              AXI4-Lite write address/data/response
//   ar*/r*                 AXI4-Lite read address/data
//   irq                    registered |(DONE & IRQ_MASK), LED_PWM_IRQ_EN only
//   LED[NUM_CH-1:0]        board LED pins (inverted when INVERSE_MODE=1)
//
// Register map (byte addresses):
//   0x00 CTRL      bit0 run (reset 1), bit1 global_en (reset 0)
//   0x04 STATUS    RO, raw LED state before inversion
//   0x08 DONE      W1C, one-shot done flags
//   0x0C IRQ_MASK  RW with LED_PWM_IRQ_EN, otherwise reads 0
//   0x10+8*i CFG   [1:0] mode, [8+PWM_W-1:8] duty
//   0x14+8*i PERIOD
//
// Optional feature macro: LED_PWM_IRQ_EN.
module axi_led_pwm_nch #(
    parameter int NUM_CH       = 3,
    parameter int PWM_W        = 8,
    parameter bit INVERSE_MODE = 1'b1,
    parameter int ADDR_W       = 7
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
`ifdef LED_PWM_IRQ_EN
    output logic              irq,
`endif
    output logic [NUM_CH-1:0] LED
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] M_OFF    = 2'b00;
    localparam logic [1:0] M_STEADY = 2'b01;
    localparam logic [1:0] M_BLINK  = 2'b10;
    localparam logic [1:0] M_SHOT   = 2'b11;

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] A_DONE   = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(8'h0C);

    function automatic logic [ADDR_W-1:0] cfg_addr(input int i);
        return ADDR_W'(16 + 8 * i);
    endfunction

    function automatic logic [ADDR_W-1:0] per_addr(input int i);
        return ADDR_W'(20 + 8 * i);
    endfunction

    // AXI handshake state
    logic        awready_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    // Control / channel state
    logic                          run_q;
    logic                          en_q;
    logic [NUM_CH-1:0]             done_q;
    logic [NUM_CH-1:0]             done_d;
    logic [NUM_CH-1:0]             done_set;
    logic [NUM_CH-1:0][1:0]        mode_q;
    logic [NUM_CH-1:0][1:0]        mode_d;
    logic [NUM_CH-1:0][PWM_W-1:0]  duty_q;
    logic [NUM_CH-1:0][PWM_W-1:0]  duty_d;
    logic [NUM_CH-1:0][31:0]       per_q;
    logic [NUM_CH-1:0][31:0]       per_d;
    logic [NUM_CH-1:0][31:0]       tmr_q;
    logic [NUM_CH-1:0][31:0]       tmr_d;
    logic [NUM_CH-1:0]             phase_q;
    logic [NUM_CH-1:0]             phase_d;
    logic [PWM_W-1:0]              pwm_cnt_q;
    logic [PWM_W-1:0]              pwm_cnt_d;
    logic [NUM_CH-1:0]             pwm_on;
    logic [NUM_CH-1:0]             raw;
    logic [NUM_CH-1:0]             led_q;
    logic [NUM_CH-1:0]             led_d;

    // Decode
    logic              wr_en;
    logic              rd_en;
    logic              wr_map;
    logic              wr_ctrl;
    logic              wr_done;
    logic [NUM_CH-1:0] wr_cfg;
    logic [NUM_CH-1:0] wr_per;
    logic              rd_map;
    logic [31:0]       rd_data;

`ifdef LED_PWM_IRQ_EN
    logic              wr_mask;
    logic [NUM_CH-1:0] mask_q;
    logic              irq_q;
`endif

    logic unused_ok;
    assign unused_ok = ^{awprot, wstrb, arprot};

    // Valids are held by the master while awready/arready is high,
    // so the accept cycle is the cycle the register update happens.
    assign wr_en = awready_q & awvalid & wvalid;
    assign rd_en = arready_q & arvalid;

    always_comb begin
        wr_map  = 1'b0;
        wr_ctrl = 1'b0;
        wr_done = 1'b0;
        wr_cfg  = '0;
        wr_per  = '0;
`ifdef LED_PWM_IRQ_EN
        wr_mask = 1'b0;
`endif
        if (awaddr == A_CTRL) begin
            wr_map  = 1'b1;
            wr_ctrl = wr_en;
        end
        if (awaddr == A_STATUS) begin
            wr_map = 1'b1;
        end
        if (awaddr == A_DONE) begin
            wr_map  = 1'b1;
            wr_done = wr_en;
        end
        if (awaddr == A_MASK) begin
            wr_map = 1'b1;
`ifdef LED_PWM_IRQ_EN
            wr_mask = wr_en;
`endif
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (awaddr == cfg_addr(i)) begin
                wr_map    = 1'b1;
                wr_cfg[i] = wr_en;
            end
            if (awaddr == per_addr(i)) begin
                wr_map    = 1'b1;
                wr_per[i] = wr_en;
            end
        end
    end

    always_comb begin
        rd_map  = 1'b0;
        rd_data = '0;
        if (araddr == A_CTRL) begin
            rd_map       = 1'b1;
            rd_data[1:0] = {en_q, run_q};
        end
        if (araddr == A_STATUS) begin
            rd_map              = 1'b1;
            rd_data[NUM_CH-1:0] = raw;
        end
        if (araddr == A_DONE) begin
            rd_map              = 1'b1;
            rd_data[NUM_CH-1:0] = done_q;
        end
        if (araddr == A_MASK) begin
            rd_map = 1'b1;
`ifdef LED_PWM_IRQ_EN
            rd_data[NUM_CH-1:0] = mask_q;
`endif
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (araddr == cfg_addr(i)) begin
                rd_map             = 1'b1;
                rd_data[1:0]       = mode_q[i];
                rd_data[8+:PWM_W]  = duty_q[i];
            end
            if (araddr == per_addr(i)) begin
                rd_map  = 1'b1;
                rd_data = per_q[i];
            end
        end
    end

    // PWM compare and raw LED state
    always_comb begin
        pwm_on = '0;
        raw    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_on[i] = (&duty_q[i]) | (pwm_cnt_q < duty_q[i]);
            unique case (mode_q[i])
                M_OFF:    raw[i] = 1'b0;
                M_STEADY: raw[i] = en_q & run_q & pwm_on[i];
                default:  raw[i] = en_q & run_q & pwm_on[i] & phase_q[i];
            endcase
        end
    end

    assign pwm_cnt_d = run_q ? pwm_cnt_q + PWM_W'(1) : '0;
    assign led_d     = raw ^ {NUM_CH{INVERSE_MODE}};

    // Channel timers; a CFG write overrides any same-cycle expiry
    // while the expiry's DONE flag still sets.
    always_comb begin
        mode_d   = mode_q;
        duty_d   = duty_q;
        per_d    = per_q;
        tmr_d    = tmr_q;
        phase_d  = phase_q;
        done_set = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!run_q) begin
                tmr_d[i]   = '0;
                phase_d[i] = 1'b1;
            end else begin
                unique case (mode_q[i])
                    M_BLINK: begin
                        // >= also recovers from PERIOD shrunk below tmr
                        if (tmr_q[i] >= per_q[i]) begin
                            tmr_d[i]   = '0;
                            phase_d[i] = ~phase_q[i];
                        end else begin
                            tmr_d[i] = tmr_q[i] + 32'd1;
                        end
                    end
                    M_SHOT: begin
                        if (tmr_q[i] >= per_q[i]) begin
                            tmr_d[i]    = '0;
                            mode_d[i]   = M_OFF;
                            done_set[i] = 1'b1;
                        end else begin
                            tmr_d[i] = tmr_q[i] + 32'd1;
                        end
                    end
                    default: begin
                        tmr_d[i]   = '0;
                        phase_d[i] = 1'b1;
                    end
                endcase
            end
            if (wr_cfg[i]) begin
                mode_d[i]  = wdata[1:0];
                duty_d[i]  = wdata[8+:PWM_W];
                tmr_d[i]   = '0;
                phase_d[i] = 1'b1;
            end
            if (wr_per[i]) begin
                per_d[i] = wdata;
            end
        end
    end

    // W1C clear loses to a same-cycle set
    always_comb begin
        done_d = done_q;
        if (wr_done) begin
            done_d = done_q & ~wdata[NUM_CH-1:0];
        end
        done_d = done_d | done_set;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            run_q     <= 1'b1;
            en_q      <= 1'b0;
            done_q    <= '0;
            mode_q    <= '0;
            duty_q    <= '0;
            per_q     <= '0;
            tmr_q     <= '0;
            phase_q   <= '1;
            pwm_cnt_q <= '0;
            led_q     <= {NUM_CH{INVERSE_MODE}};
        end else begin
            if (wr_ctrl) begin
                run_q <= wdata[0];
                en_q  <= wdata[1];
            end
            done_q    <= done_d;
            mode_q    <= mode_d;
            duty_q    <= duty_d;
            per_q     <= per_d;
            tmr_q     <= tmr_d;
            phase_q   <= phase_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    // AXI write and read response channels
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            awready_q <= awvalid & wvalid & ~bvalid_q & ~awready_q;
            if (wr_en) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_map ? RESP_OKAY : RESP_SLVERR;
            end else if (bready) begin
                bvalid_q <= 1'b0;
            end

            arready_q <= arvalid & ~rvalid_q & ~arready_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_map ? rd_data : 32'd0;
                rresp_q  <= rd_map ? RESP_OKAY : RESP_SLVERR;
            end else if (rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

`ifdef LED_PWM_IRQ_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_mask) begin
                mask_q <= wdata[NUM_CH-1:0];
            end
            irq_q <= |(done_q & mask_q);
        end
    end

    assign irq = irq_q;
`endif

    assign awready = awready_q;
    assign wready  = awready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign LED     = led_q;

endmodule

// File: tb/tb_axi_led_pwm_nch.sv
// tb_axi_led_pwm_nch: directed bench for axi_led_pwm_nch
// (NUM_CH=3, PWM_W=8, INVERSE_MODE=1, ADDR_W=7).
module tb_axi_led_pwm_nch;

    localparam logic [6:0] A_CTRL   = 7'h00;
    localparam logic [6:0] A_STATUS = 7'h04;
    localparam logic [6:0] A_DONE   = 7'h08;
    localparam logic [6:0] A_MASK   = 7'h0C;
    localparam logic [6:0] A_CFG0   = 7'h10;
    localparam logic [6:0] A_CFG1   = 7'h18;
    localparam logic [6:0] A_PER1   = 7'h1C;
    localparam logic [6:0] A_CFG2   = 7'h20;
    localparam logic [6:0] A_PER2   = 7'h24;
    localparam logic [6:0] A_BAD    = 7'h7C;

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b0;
    logic [6:0]  awaddr  = '0;
    logic [2:0]  awprot  = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata   = '0;
    logic [3:0]  wstrb   = 4'hF;
    logic        wvalid  = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready  = 1'b0;
    logic [6:0]  araddr  = '0;
    logic [2:0]  arprot  = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready  = 1'b0;
`ifdef LED_PWM_IRQ_EN
    logic        irq;
`endif
    logic [2:0]  LED;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    axi_led_pwm_nch #(
        .NUM_CH(3),
        .PWM_W(8),
        .INVERSE_MODE(1'b1),
        .ADDR_W(7)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .awaddr(awaddr),
        .awprot(awprot),
        .awvalid(awvalid),
        .awready(awready),
        .wdata(wdata),
        .wstrb(wstrb),
        .wvalid(wvalid),
        .wready(wready),
        .bresp(bresp),
        .bvalid(bvalid),
        .bready(bready),
        .araddr(araddr),
        .arprot(arprot),
        .arvalid(arvalid),
        .arready(arready),
        .rdata(rdata),
        .rresp(rresp),
        .rvalid(rvalid),
        .rready(rready),
`ifdef LED_PWM_IRQ_EN
        .irq(irq),
`endif
        .LED(LED)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // hold>0 keeps the valids up and bready low for that many cycles
    task automatic axi_wr(input logic [6:0] a, input logic [31:0] d,
                          input int hold, output logic [1:0] resp);
        int n;
        @(negedge aclk);
        awaddr  = a;
        wdata   = d;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!awready && n < 20);
        check("aw_ready", {awready, wready}, 2'b11);
        @(negedge aclk);
        check("b_valid", bvalid, 1'b1);
        resp = bresp;
        for (int k = 0; k < hold; k++) begin
            check("b_hold", {awready, wready, bvalid}, 3'b001);
            @(negedge aclk);
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        @(negedge aclk);
        bready  = 1'b0;
    endtask

    task automatic axi_rd(input logic [6:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
        int n;
        @(negedge aclk);
        araddr  = a;
        arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!arready && n < 20);
        check("ar_ready", arready, 1'b1);
        @(negedge aclk);
        check("r_valid", rvalid, 1'b1);
        d       = rdata;
        resp    = rresp;
        arvalid = 1'b0;
        rready  = 1'b1;
        @(negedge aclk);
        rready  = 1'b0;
    endtask

    // cycles within n where LED[ch] is lit (active-low pins)
    task automatic count_on(input int ch, input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge aclk);
            if (LED[ch] == 1'b0) cnt++;
        end
    endtask

    // length of the current run of LED[ch] at level lvl
    task automatic run_len(input int ch, input logic lvl, output int cnt);
        cnt = 0;
        while (LED[ch] === lvl && cnt < 300) begin
            cnt++;
            @(negedge aclk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          c;

        // reset state
        repeat (3) @(negedge aclk);
        check("rst_led", LED, 3'b111);
        check("rst_hs", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        check("rst_resp", {bresp, rresp}, 4'b0);
        check("rst_rdata", rdata, 32'h0);
        aresetn = 1'b1;

        axi_rd(A_CTRL, d, r);
        check("ctrl_rst", d, 32'h1);
        check("ctrl_rst_resp", r, 2'b00);
        axi_rd(A_STATUS, d, r);
        check("status_rst", d, 32'h0);

        // steady PWM
        axi_wr(A_CTRL, 32'h3, 0, r);
        check("ctrl_wr_resp", r, 2'b00);
        axi_wr(A_CFG0, 32'h4001, 0, r);
        repeat (2) @(negedge aclk);
        count_on(0, 256, c);
        check("pwm_40", c, 64);
        check("others_dark", LED[2:1], 2'b11);

        axi_wr(A_CFG0, 32'hFF01, 0, r);
        repeat (2) @(negedge aclk);
        count_on(0, 256, c);
        check("pwm_ff", c, 256);
        axi_rd(A_STATUS, d, r);
        check("status_ch0", d, 32'h1);
        axi_rd(A_CFG0, d, r);
        check("cfg0_rd", d, 32'hFF01);

        axi_wr(A_CFG0, 32'h0001, 0, r);
        repeat (2) @(negedge aclk);
        count_on(0, 256, c);
        check("pwm_00", c, 0);
        axi_wr(A_CFG0, 32'h0, 0, r);

        // blink, half-period 10, first half on
        axi_wr(A_PER1, 32'd9, 0, r);
        axi_wr(A_CFG1, 32'hFF02, 0, r);
        check("blink_first_on", LED[1], 1'b0);
        run_len(1, 1'b0, c);
        check("blink_on_len", c, 10);
        run_len(1, 1'b1, c);
        check("blink_off_len", c, 10);

        // blink, PERIOD=0 toggles each cycle
        axi_wr(A_PER1, 32'd0, 0, r);
        axi_wr(A_CFG1, 32'hFF02, 0, r);
        run_len(1, 1'b0, c);
        check("blink0_on", c, 1);
        run_len(1, 1'b1, c);
        check("blink0_off", c, 1);
        run_len(1, 1'b0, c);
        check("blink0_on2", c, 1);
        axi_wr(A_CFG1, 32'h0, 0, r);

        // one-shot, 5 cycles
        axi_wr(A_PER2, 32'd4, 0, r);
        axi_wr(A_CFG2, 32'hFF03, 0, r);
        run_len(2, 1'b0, c);
        check("shot_len", c, 5);
        repeat (3) @(negedge aclk);
        check("shot_dark", LED[2], 1'b1);
        axi_rd(A_CFG2, d, r);
        check("shot_mode_clr", d, 32'hFF00);
        axi_rd(A_DONE, d, r);
        check("done_set", d, 32'h4);
        axi_wr(A_DONE, 32'h4, 0, r);
        axi_rd(A_DONE, d, r);
        check("done_w1c", d, 32'h0);

        // W1C lands on the expiry cycle: set wins
        axi_wr(A_CFG2, 32'hFF03, 0, r);
        @(negedge aclk);
        axi_wr(A_DONE, 32'h4, 0, r);
        axi_rd(A_DONE, d, r);
        check("done_collide", d, 32'h4);
        axi_wr(A_DONE, 32'h4, 0, r);
        axi_rd(A_DONE, d, r);
        check("done_clr2", d, 32'h0);

`ifdef LED_PWM_IRQ_EN
        axi_wr(A_MASK, 32'h4, 0, r);
        axi_rd(A_MASK, d, r);
        check("mask_rd", d, 32'h4);
        axi_wr(A_CFG2, 32'hFF03, 0, r);
        check("irq_idle", irq, 1'b0);
        repeat (4) @(negedge aclk);
        check("irq_pre", irq, 1'b0);
        @(negedge aclk);
        check("irq_rise", irq, 1'b1);
        axi_wr(A_DONE, 32'h4, 0, r);
        check("irq_fall", irq, 1'b0);
`else
        axi_wr(A_MASK, 32'h7, 0, r);
        check("mask_wr_resp", r, 2'b00);
        axi_rd(A_MASK, d, r);
        check("mask_rd0", d, 32'h0);
        check("mask_rd_resp", r, 2'b00);
`endif

        // unmapped write, slow bready
        axi_wr(A_BAD, 32'hFFFF_FFFF, 5, r);
        check("bad_wr_resp", r, 2'b10);
        axi_rd(A_CTRL, d, r);
        check("bad_ctrl", d, 32'h3);
        axi_rd(A_PER2, d, r);
        check("bad_per2", d, 32'h4);
        axi_rd(A_CFG0, d, r);
        check("bad_cfg0", d, 32'h0);
        axi_rd(A_BAD, d, r);
        check("bad_rd_data", d, 32'h0);
        check("bad_rd_resp", r, 2'b10);

        // run=0 darkens, registers retained
        axi_wr(A_CFG0, 32'hFF01, 0, r);
        axi_wr(A_CTRL, 32'h2, 0, r);
        repeat (2) @(negedge aclk);
        count_on(0, 40, c);
        check("run0_dark", c, 0);
        axi_rd(A_CFG0, d, r);
        check("run0_cfg0", d, 32'hFF01);
        axi_wr(A_CTRL, 32'h3, 0, r);
        repeat (2) @(negedge aclk);
        count_on(0, 40, c);
        check("run1_on", c, 40);

        // reset in the middle of a transaction
        @(negedge aclk);
        awaddr  = A_CTRL;
        wdata   = 32'h0;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        araddr  = A_CTRL;
        arvalid = 1'b1;
        @(negedge aclk);
        check("mid_accept", {awready, arready}, 2'b11);
        aresetn = 1'b0;
        #1;
        check("mid_rst_hs", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        check("mid_no_resp", {bvalid, rvalid}, 2'b00);
        check("mid_led", LED, 3'b111);
        axi_rd(A_CTRL, d, r);
        check("mid_ctrl", d, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
